// File: rtl/point_generator_pkg.sv
// Shared constants and types for the Mandelbrot escape-time point engine.
package point_generator_pkg;

    localparam int PG_HBP  = 64;
    localparam int PG_HBS  = 64;
    localparam int PG_HBI  = 64;
    localparam int PG_FRAC = 56;
    localparam int COORD_W = 12;

    localparam logic signed [PG_HBP+1:0] ESCAPE_LIMIT =
        66'sd4 <<< PG_FRAC;

    typedef enum logic [1:0] {
        SETUP,
        ITER,
        DONE
    } state_t;

endpackage

// File: rtl/point_generator_fxp_mul.sv
// Signed fixed-point multiply: full product, arithmetic shift by FRAC,
// truncated back to the operand width.
module fxp_mul #(
    parameter int HBP  = 64,
    parameter int FRAC = 56
) (
    input  logic signed [HBP:0] a,
    input  logic signed [HBP:0] b,
    output logic signed [HBP:0] p
);

    logic signed [2*HBP+1:0] full;

    assign full = (2*HBP+2)'(a) * (2*HBP+2)'(b);
    assign p    = (HBP+1)'(full >>> FRAC);

endmodule

// File: rtl/point_generator.sv
// Per-pixel Mandelbrot escape-time engine: maps (x, y) to c and iterates
// z <- z^2 + c once per clock until escape or the iteration cap.
import point_generator_pkg::*;

module point_generator #(
    parameter int HBP  = PG_HBP,
    parameter int HBS  = PG_HBS,
    parameter int HBI  = PG_HBI,
    parameter int FRAC = PG_FRAC
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic [HBS:0]         re_scale,
    input  logic [HBS:0]         im_scale,
    input  logic [COORD_W-1:0]   x,
    input  logic [COORD_W-1:0]   y,
    input  logic [HBI:0]         max_iterations,
    input  logic signed [HBP:0]  re_start,
    input  logic signed [HBP:0]  im_start,
    output logic                 ready,
    output logic [HBI:0]         iteration
);

    localparam int OFF_W = HBS + 1 + COORD_W;

    localparam logic signed [HBP+1:0] ESC_LIM =
        (HBP+2)'(4) <<< FRAC;

    state_t state;

    logic signed [HBP:0]   zr;
    logic signed [HBP:0]   zi;
    logic signed [HBP:0]   c_re;
    logic signed [HBP:0]   c_im;
    logic signed [HBP:0]   zr2;
    logic signed [HBP:0]   zi2;
    logic signed [HBP:0]   zrzi;
    logic signed [HBP+1:0] mag;
    logic [HBI:0]          count;
    logic [HBI:0]          max_q;
    logic [COORD_W-1:0]    x_q;
    logic [COORD_W-1:0]    y_q;
    logic [OFF_W-1:0]      re_off;
    logic [OFF_W-1:0]      im_off;
    logic                  escape;
    logic                  moved;

    fxp_mul #(.HBP(HBP), .FRAC(FRAC)) u_sq_re (
        .a (zr),
        .b (zr),
        .p (zr2)
    );

    fxp_mul #(.HBP(HBP), .FRAC(FRAC)) u_sq_im (
        .a (zi),
        .b (zi),
        .p (zi2)
    );

    fxp_mul #(.HBP(HBP), .FRAC(FRAC)) u_cross (
        .a (zr),
        .b (zi),
        .p (zrzi)
    );

    assign re_off = OFF_W'(x) * OFF_W'(re_scale);
    assign im_off = OFF_W'(y) * OFF_W'(im_scale);

    // One guard bit so two large squares cannot wrap below the limit.
    assign mag    = (HBP+2)'(zr2) + (HBP+2)'(zi2);
    assign escape = mag > ESC_LIM;

    assign moved = (x != x_q) || (y != y_q);
    assign ready = (state == DONE) && !moved;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state     <= SETUP;
            zr        <= '0;
            zi        <= '0;
            c_re      <= '0;
            c_im      <= '0;
            count     <= '0;
            max_q     <= '0;
            iteration <= '0;
            x_q       <= '0;
            y_q       <= '0;
        end else begin
            unique case (state)
                SETUP: begin
                    x_q   <= x;
                    y_q   <= y;
                    c_re  <= re_start + (HBP+1)'(re_off);
                    c_im  <= im_start + (HBP+1)'(im_off);
                    zr    <= '0;
                    zi    <= '0;
                    count <= '0;
                    max_q <= max_iterations;
                    state <= ITER;
                end
                ITER: begin
                    if (escape || (count == max_q)) begin
                        iteration <= count;
                        state     <= DONE;
                    end else begin
                        zr    <= zr2 - zi2 + c_re;
                        zi    <= (zrzi <<< 1) + c_im;
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    if (moved) begin
                        state <= SETUP;
                    end
                end
                default: state <= SETUP;
            endcase
        end
    end

endmodule

// File: tb/tb_point_generator.sv
// Self-checking bench for point_generator: directed corner cases plus
// randomized pixels against an escape-time reference loop.
module tb_point_generator;

    localparam logic signed [64:0] ONE  = 65'sd1 <<< 56;
    localparam logic [64:0]        HALF = 65'd1 << 55;
    localparam logic [64:0]        EIGHTH = 65'd1 << 53;
    localparam logic signed [65:0] LIM  = 66'sd4 <<< 56;

    logic               CLK;
    logic               reset;
    logic [64:0]        re_scale;
    logic [64:0]        im_scale;
    logic [11:0]        x;
    logic [11:0]        y;
    logic [64:0]        max_iterations;
    logic signed [64:0] re_start;
    logic signed [64:0] im_start;
    logic               ready;
    logic [64:0]        iteration;

    int n_cmp;
    int n_bad;

    point_generator dut (
        .CLK            (CLK),
        .reset          (reset),
        .re_scale       (re_scale),
        .im_scale       (im_scale),
        .x              (x),
        .y              (y),
        .max_iterations (max_iterations),
        .re_start       (re_start),
        .im_start       (im_start),
        .ready          (ready),
        .iteration      (iteration)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [64:0] got,
                         input logic [64:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [64:0] fmul(
        input logic signed [64:0] a, input logic signed [64:0] b);
        logic signed [129:0] p;
        p = 130'(a) * 130'(b);
        return 65'(p >>> 56);
    endfunction

    // Escape-time count for pixel (px, py), straight from the recurrence.
    function automatic longint unsigned model(
        input logic signed [64:0] rs, input logic [64:0] rsc,
        input logic signed [64:0] ist, input logic [64:0] isc,
        input int unsigned px, input int unsigned py,
        input longint unsigned mi);
        logic signed [64:0] cr, ci, zr, zi, a, b, m;
        logic signed [65:0] s;
        cr = rs + 65'(px) * rsc;
        ci = ist + 65'(py) * isc;
        zr = '0;
        zi = '0;
        for (longint unsigned k = 0; k < mi; k++) begin
            a = fmul(zr, zr);
            b = fmul(zi, zi);
            m = fmul(zr, zi);
            s = 66'(a) + 66'(b);
            if (s > LIM) return k;
            zr = a - b + cr;
            zi = (m <<< 1) + ci;
        end
        return mi;
    endfunction

    task automatic wait_ready(input logic [64:0] held, output int cyc);
        logic [64:0] seen;
        seen = held;
        cyc = 0;
        do begin
            @(posedge CLK);
            #1;
            cyc++;
            if (!ready && iteration !== held) seen = iteration;
        end while (!ready && cyc < 4000);
        check("hold", seen, held);
        if (!ready) check("timeout", 65'(ready), 65'd1);
    endtask

    task automatic run_change(input logic [11:0] nx, input logic [11:0] ny,
                              input logic [64:0] held, output int cyc);
        @(negedge CLK);
        x = nx;
        y = ny;
        #1;
        check("drop", 65'(ready), 65'd0);
        wait_ready(held, cyc);
    endtask

    initial begin
        int cyc;
        logic [11:0] nx, ny;
        longint unsigned mi, exp_k, last;

        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        re_start = -(ONE <<< 1);
        im_start = '0;
        re_scale = HALF;
        im_scale = HALF;
        max_iterations = 65'd255;
        x = 12'd0;
        y = 12'd0;

        repeat (2) @(negedge CLK);
        check("rst_ready", 65'(ready), 65'd0);
        check("rst_iter", iteration, 65'd0);
        reset = 1'b0;
        wait_ready(65'd0, cyc);
        check("cm2_iter", iteration, 65'd255);
        check("cm2_cyc", 65'(cyc), 65'd257);

        run_change(12'd8, 12'd0, 65'd255, cyc);
        check("c2_iter", iteration, 65'd2);
        check("c2_cyc", 65'(cyc), 65'd5);

        run_change(12'd5, 12'd0, 65'd2, cyc);
        check("c05_iter", iteration, 65'd5);

        run_change(12'd4, 12'd3, 65'd5, cyc);
        check("ci15_iter", iteration, 65'd2);

        max_iterations = 65'd0;
        run_change(12'd7, 12'd1, 65'd2, cyc);
        check("max0_iter", iteration, 65'd0);
        check("max0_cyc", 65'(cyc), 65'd3);

        @(negedge CLK);
        reset = 1'b1;
        x = 12'd9;
        y = 12'd2;
        @(negedge CLK);
        reset = 1'b0;
        wait_ready(65'd0, cyc);
        check("max0r_iter", iteration, 65'd0);
        check("max0r_cyc", 65'(cyc), 65'd2);

        max_iterations = 65'd255;
        run_change(12'd8, 12'd0, 65'd0, cyc);
        check("c2b_iter", iteration, 65'd2);
        run_change(12'd4, 12'd0, 65'd2, cyc);
        check("c0_iter", iteration, 65'd255);
        check("c0_cyc", 65'(cyc), 65'd258);

        @(negedge CLK);
        x = 12'd0;
        repeat (10) @(negedge CLK);
        x = 12'd5;
        repeat (10) @(negedge CLK);
        check("iter_busy", 65'(ready), 65'd0);
        check("iter_keep", iteration, 65'd255);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_ready", 65'(ready), 65'd0);
        check("mid_rst_iter", iteration, 65'd0);
        @(negedge CLK);
        reset = 1'b0;
        wait_ready(65'd0, cyc);
        check("after_rst_iter", iteration, 65'd5);
        check("after_rst_cyc", 65'(cyc), 65'd7);

        @(negedge CLK);
        re_start = -(ONE <<< 1);
        im_start = -ONE;
        re_scale = EIGHTH;
        im_scale = EIGHTH;
        last = 5;
        for (int i = 0; i < 40; i++) begin
            nx = 12'($urandom_range(0, 31));
            ny = 12'($urandom_range(0, 15));
            mi = longint'($urandom_range(0, 60));
            exp_k = model(re_start, re_scale, im_start, im_scale,
                          nx, ny, mi);
            if (nx == x && ny == y) begin
                @(negedge CLK);
                reset = 1'b1;
                max_iterations = 65'(mi);
                @(negedge CLK);
                reset = 1'b0;
                wait_ready(65'd0, cyc);
                check("rnd_cyc", 65'(cyc), 65'(exp_k + 2));
            end else begin
                max_iterations = 65'(mi);
                run_change(nx, ny, 65'(last), cyc);
                check("rnd_cyc", 65'(cyc), 65'(exp_k + 3));
            end
            check("rnd_iter", iteration, 65'(exp_k));
            last = exp_k;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
